// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM, console FIFO and cycle counter MMIO.
// Console FIFO is built only when DMEM_CONSOLE_EN is defined.
module dmem_responder #(
    parameter int RAM_AW    = 12,
    parameter int CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_d,
    input  logic [3:0]  dmem_we,
    output logic [31:0] dmem_q,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic              is_mmio;
    logic [1:0]        off;
    logic [63:0]       cycle_cnt;
    logic [31:0]       shadow;
    logic [31:0]       con_status;
    logic [31:0]       mmio_rd;
    logic              unused_addr;

    assign ram_idx     = dmem_addr[RAM_AW+1:2];
    assign is_mmio     = dmem_addr[31];
    assign off         = dmem_addr[3:2];
    assign unused_addr = ^{dmem_addr[30:RAM_AW+2], dmem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (dmem_en && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_we[i]) ram[ram_idx][8*i +: 8] <= dmem_d[8*i +: 8];
            end
        end
    end

    always_comb begin
        mmio_rd = '0;
        unique case (off)
            2'd0:    mmio_rd = '0;
            2'd1:    mmio_rd = con_status;
            2'd2:    mmio_rd = cycle_cnt[31:0];
            default: mmio_rd = shadow;
        endcase
    end

    // Read-before-write: dmem_q samples the word as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_q    <= '0;
            cycle_cnt <= '0;
            shadow    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (dmem_en) begin
                dmem_q <= is_mmio ? mmio_rd : ram[ram_idx];
                if (is_mmio && off == 2'd2) shadow <= cycle_cnt[63:32];
            end
        end
    end

`ifdef DMEM_CONSOLE_EN
    localparam int CW = $clog2(CON_DEPTH);

    logic [7:0]    fifo [CON_DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW:0]   count;
    logic [CW:0]   count_nxt;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_clr;

    assign full      = count == (CW+1)'(CON_DEPTH);
    assign empty     = count == '0;
    assign pop       = !empty && con_ready;
    assign push_req  = dmem_en && is_mmio && off == 2'd0 && dmem_we[0];
    assign push_ok   = push_req && (!full || pop);
    assign ovf_clr   = dmem_en && is_mmio && off == 2'd1
                       && dmem_we[0] && dmem_d[3];
    assign count_nxt = count + (CW+1)'(push_ok) - (CW+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            con_valid <= 1'b0;
            for (int i = 0; i < CON_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (push_ok) begin
                fifo[wr_ptr] <= dmem_d[7:0];
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            con_valid <= count_nxt != '0;
            // A dropped push on the same edge as a clear keeps the flag set.
            if (push_req && !push_ok) ovf <= 1'b1;
            else if (ovf_clr)         ovf <= 1'b0;
        end
    end

    assign con_data   = fifo[rd_ptr];
    assign con_status = {24'b0, 4'(count), ovf, empty, full, 1'b0};
`else
    logic unused_con;

    assign unused_con = con_ready;
    assign con_valid  = 1'b0;
    assign con_data   = '0;
    assign con_status = '0;
`endif

endmodule
